// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes and the master bridge state type.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RESP
    } axil_mst_state_t;

    // Anything other than OKAY is reported to the requester as an error,
    // including EXOKAY, which an AXI4-Lite slave has no business returning.
    function automatic logic resp_is_err(input logic [1:0] resp);
        logic err;
        case (resp)
            RESP_OKAY:   err = 1'b0;
            RESP_EXOKAY: err = 1'b1;
            RESP_SLVERR: err = 1'b1;
            RESP_DECERR: err = 1'b1;
            default:     err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/axil_master_bridge.sv
// Single-outstanding request/response port to AXI4-Lite master bridge.
// Every AXI output and req_ready comes straight from a flop; the comb block
// only computes the next register values.
import axil_pkg::*;

module axil_master_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0] req_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    axil_mst_state_t       state, state_nx;

    logic [ADDR_WIDTH-1:0] addr_q,  addr_nx;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_nx;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_nx;
    logic                  aw_done, aw_done_nx;
    logic                  w_done,  w_done_nx;

    logic                  awvalid_nx, wvalid_nx, bready_nx;
    logic                  arvalid_nx, rready_nx;
    logic                  rsp_valid_nx, rsp_err_nx, req_ready_nx;
    logic [DATA_WIDTH-1:0] rsp_rdata_nx;

    // Read and write share one latched address; only one channel is active.
    assign m_axil_awaddr = addr_q;
    assign m_axil_araddr = addr_q;
    assign m_axil_wdata  = wdata_q;
    assign m_axil_wstrb  = wstrb_q;
    assign m_axil_awprot = 3'b000;
    assign m_axil_arprot = 3'b000;

    // Next-state and next-output computation; every register holds by default.
    always_comb begin
        state_nx      = state;
        addr_nx       = addr_q;
        wdata_nx      = wdata_q;
        wstrb_nx      = wstrb_q;
        aw_done_nx    = aw_done;
        w_done_nx     = w_done;
        awvalid_nx    = m_axil_awvalid;
        wvalid_nx     = m_axil_wvalid;
        bready_nx     = m_axil_bready;
        arvalid_nx    = m_axil_arvalid;
        rready_nx     = m_axil_rready;
        rsp_valid_nx  = rsp_valid;
        rsp_err_nx    = rsp_err;
        rsp_rdata_nx  = rsp_rdata;

        case (state)
            IDLE: begin
                // The request direction is remembered by which state we enter.
                if (req_valid && req_ready) begin
                    addr_nx  = req_addr;
                    wdata_nx = req_wdata;
                    wstrb_nx = req_wstrb;
                    if (req_we) begin
                        awvalid_nx = 1'b1;
                        wvalid_nx  = 1'b1;
                        aw_done_nx = 1'b0;
                        w_done_nx  = 1'b0;
                        state_nx   = WR;
                    end else begin
                        arvalid_nx = 1'b1;
                        state_nx   = RD_ADDR;
                    end
                end
            end
            WR: begin
                if (m_axil_awvalid && m_axil_awready) begin
                    awvalid_nx = 1'b0;
                    aw_done_nx = 1'b1;
                end
                if (m_axil_wvalid && m_axil_wready) begin
                    wvalid_nx = 1'b0;
                    w_done_nx = 1'b1;
                end
                // bready only rises once both halves of the write are out, so an
                // early B beat can never be taken.
                if (aw_done_nx && w_done_nx) begin
                    bready_nx = 1'b1;
                    state_nx  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_axil_bvalid && m_axil_bready) begin
                    bready_nx    = 1'b0;
                    rsp_err_nx   = resp_is_err(m_axil_bresp);
                    rsp_rdata_nx = '0;
                    rsp_valid_nx = 1'b1;
                    state_nx     = RESP;
                end
            end
            RD_ADDR: begin
                if (m_axil_arvalid && m_axil_arready) begin
                    arvalid_nx = 1'b0;
                    rready_nx  = 1'b1;
                    state_nx   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_axil_rvalid && m_axil_rready) begin
                    rready_nx    = 1'b0;
                    rsp_rdata_nx = m_axil_rdata;
                    rsp_err_nx   = resp_is_err(m_axil_rresp);
                    rsp_valid_nx = 1'b1;
                    state_nx     = RESP;
                end
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    rsp_valid_nx = 1'b0;
                    state_nx     = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        req_ready_nx = (state_nx == IDLE);
    end

    // State and all registered outputs; asynchronous reset abandons any transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            m_axil_awvalid <= 1'b0;
            m_axil_wvalid  <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_err        <= 1'b0;
            rsp_rdata      <= '0;
            req_ready      <= 1'b0;
        end else begin
            state          <= state_nx;
            addr_q         <= addr_nx;
            wdata_q        <= wdata_nx;
            wstrb_q        <= wstrb_nx;
            aw_done        <= aw_done_nx;
            w_done         <= w_done_nx;
            m_axil_awvalid <= awvalid_nx;
            m_axil_wvalid  <= wvalid_nx;
            m_axil_bready  <= bready_nx;
            m_axil_arvalid <= arvalid_nx;
            m_axil_rready  <= rready_nx;
            rsp_valid      <= rsp_valid_nx;
            rsp_err        <= rsp_err_nx;
            rsp_rdata      <= rsp_rdata_nx;
            req_ready      <= req_ready_nx;
        end
    end

endmodule

// File: tb/tb_axil_master_bridge.sv
// Directed bench for axil_master_bridge with a small behavioural AXI4-Lite slave.
module tb_axil_master_bridge;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int SW = 4;
    localparam int TMO = 60;

    logic          clk;
    logic          rst_n;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_wstrb;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata;

    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;
    logic [1:0]    bresp, rresp;

    axil_master_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
        .m_axil_awready(awready), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
        .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_bresp(bresp),
        .m_axil_bvalid(bvalid), .m_axil_bready(bready), .m_axil_araddr(araddr),
        .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
        .m_axil_rready(rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- slave configuration (written by the stimulus) -------------
    int         aw_delay = 0;
    int         r_delay  = 0;
    logic [1:0] bresp_cfg = 2'b00;
    logic [1:0] rresp_cfg = 2'b00;

    // ---------------- behavioural slave: memory of 16 words ---------------------
    logic [31:0] mem [0:15];

    initial begin
        logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;
        logic [AW-1:0] s_awaddr, s_araddr, wr_addr, rd_addr;
        logic [DW-1:0] s_wdata, wr_data;
        logic [SW-1:0] s_wstrb, wr_strb;
        logic          aw_got, w_got, r_pend;
        int            aw_cnt, r_cnt;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rresp = 0; rdata = 0;
        aw_got = 0; w_got = 0; r_pend = 0; aw_cnt = 0; r_cnt = 0;
        wr_addr = 0; wr_data = 0; wr_strb = 0; rd_addr = 0;
        forever begin
            @(negedge clk);
            aw_hs = awvalid && awready; w_hs = wvalid && wready;
            b_hs  = bvalid && bready;   ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            s_awaddr = awaddr; s_wdata = wdata; s_wstrb = wstrb; s_araddr = araddr;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                aw_got = 0; w_got = 0; r_pend = 0; aw_cnt = 0; r_cnt = 0;
            end else begin
                if (aw_hs) begin
                    awready = 0; aw_cnt = 0; aw_got = 1; wr_addr = s_awaddr;
                end else if (awvalid && !awready && !aw_got) begin
                    if (aw_cnt >= aw_delay) awready = 1;
                    else aw_cnt++;
                end
                if (w_hs) begin
                    wready = 0; w_got = 1; wr_data = s_wdata; wr_strb = s_wstrb;
                end else if (wvalid && !wready && !w_got) begin
                    wready = 1;
                end
                if (b_hs) begin
                    bvalid = 0; aw_got = 0; w_got = 0;
                end else if (aw_got && w_got && !bvalid) begin
                    for (int b = 0; b < SW; b++)
                        if (wr_strb[b]) mem[wr_addr[5:2]][8*b +: 8] = wr_data[8*b +: 8];
                    bvalid = 1; bresp = bresp_cfg;
                end
                if (ar_hs) begin
                    arready = 0; r_pend = 1; r_cnt = r_delay; rd_addr = s_araddr;
                end else if (arvalid && !arready && !r_pend) begin
                    arready = 1;
                end
                if (r_hs) begin
                    rvalid = 0;
                end else if (r_pend && !rvalid) begin
                    if (r_cnt == 0) begin
                        rvalid = 1; rdata = mem[rd_addr[5:2]]; rresp = rresp_cfg; r_pend = 0;
                    end else begin
                        r_cnt--;
                    end
                end
            end
        end
    end

    // ---------------- protocol monitor, sampled on the falling edge -------------
    int aw_hs_cnt = 0, w_hs_cnt = 0, b_hs_cnt = 0, rsp_cnt = 0;
    int wvalid_hi = 0, aw_stall = 0, rsp_hi = 0;
    int bready_early = 0, withdrawn = 0, unstable = 0;

    initial begin
        logic          seen_aw, seen_w, p_rst;
        logic          p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rspv, p_rspr;
        logic [AW-1:0] p_awaddr;
        logic [DW-1:0] p_rsp_rdata;
        logic          p_rsp_err;
        seen_aw = 0; seen_w = 0; p_rst = 0;
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
        p_rspv = 0; p_rspr = 0; p_awaddr = 0; p_rsp_rdata = 0; p_rsp_err = 0;
        forever begin
            @(negedge clk);
            if (rst_n && p_rst) begin
                if (bready && !(seen_aw && seen_w)) bready_early++;
                if ((p_awv && !p_awr && !awvalid) || (p_wv && !p_wr && !wvalid) ||
                    (p_arv && !p_arr && !arvalid) || (p_rspv && !p_rspr && !rsp_valid))
                    withdrawn++;
                if ((p_awv && !p_awr && awaddr !== p_awaddr) ||
                    (p_rspv && !p_rspr && (rsp_rdata !== p_rsp_rdata || rsp_err !== p_rsp_err)))
                    unstable++;
            end
            if (!rst_n) begin
                seen_aw = 0; seen_w = 0;
            end else begin
                if (awvalid && awready) begin aw_hs_cnt++; seen_aw = 1; end
                if (wvalid && wready)   begin w_hs_cnt++;  seen_w  = 1; end
                if (bvalid && bready)   begin b_hs_cnt++;  seen_aw = 0; seen_w = 0; end
                if (rsp_valid && rsp_ready) rsp_cnt++;
                if (wvalid) wvalid_hi++;
                if (awvalid && !awready) aw_stall++;
                if (rsp_valid) rsp_hi++;
            end
            p_rst = rst_n; p_awv = awvalid; p_awr = awready; p_wv = wvalid; p_wr = wready;
            p_arv = arvalid; p_arr = arready; p_rspv = rsp_valid; p_rspr = rsp_ready;
            p_awaddr = awaddr; p_rsp_rdata = rsp_rdata; p_rsp_err = rsp_err;
        end
    end

    // ---------------- requester-side helpers -------------------------------------
    task automatic issue(input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
        int n;
        n = 0;
        req_valid = 1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
        while (req_ready !== 1'b1 && n < TMO) begin
            @(posedge clk); #1; n++;
        end
        check("accept_timeout", 32'(n >= TMO), 0);
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    task automatic wait_rsp(output logic [DW-1:0] d, output logic e);
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < TMO) begin
            @(posedge clk); #1; n++;
        end
        check("rsp_timeout", 32'(n >= TMO), 0);
        d = rsp_rdata; e = rsp_err;
    endtask

    task automatic consume();
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- directed stimulus ------------------------------------------
    initial begin
        logic [DW-1:0] d;
        logic          e;
        int            s_aw, s_w, s_b, s_rsp, s_whi, s_stall, s_rsphi, n, bad;

        rst_n = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
        req_wstrb = 0; rsp_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
        check("rst_rsp", {rsp_valid, rsp_err}, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_addr_regs", {awaddr, araddr}, 0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        check("post_rst_req_ready", req_ready, 1);

        // Full write then read-back
        s_aw = aw_hs_cnt; s_w = w_hs_cnt; s_b = b_hs_cnt;
        issue(1, 16'h0010, 32'hDEADBEEF, 4'hF);
        check("wr_cmd_valids", {awvalid, wvalid, req_ready}, 3'b110);
        check("wr_awaddr", awaddr, 16'h0010);
        check("wr_wdata", wdata, 32'hDEADBEEF);
        check("wr_wstrb", wstrb, 4'hF);
        check("wr_prot", {awprot, arprot}, 0);
        wait_rsp(d, e);
        check("wr_rsp_err", e, 0);
        check("wr_rsp_rdata", d, 0);
        consume();
        check("wr_aw_hs_count", aw_hs_cnt - s_aw, 1);
        check("wr_w_hs_count", w_hs_cnt - s_w, 1);
        check("wr_b_hs_count", b_hs_cnt - s_b, 1);
        check("idle_after_wr", req_ready, 1);

        issue(0, 16'h0010, 32'h0, 4'h0);
        check("rd_arvalid", arvalid, 1);
        check("rd_araddr", araddr, 16'h0010);
        wait_rsp(d, e);
        check("rd_rdata", d, 32'hDEADBEEF);
        check("rd_err", e, 0);
        consume();

        // Partial write of byte 1 only
        issue(1, 16'h0010, 32'h0000AB00, 4'b0010);
        wait_rsp(d, e);
        consume();
        issue(0, 16'h0010, 32'h0, 4'h0);
        wait_rsp(d, e);
        check("partial_rdata", d, 32'hDEADABEF);
        consume();

        // awready held off for 3 cycles, wready immediate
        aw_delay = 3;
        s_aw = aw_hs_cnt; s_w = w_hs_cnt; s_b = b_hs_cnt; s_rsp = rsp_cnt;
        s_whi = wvalid_hi; s_stall = aw_stall;
        issue(1, 16'h0014, 32'h12345678, 4'hF);
        wait_rsp(d, e);
        check("slow_aw_err", e, 0);
        consume();
        aw_delay = 0;
        check("slow_aw_wvalid_cycles", wvalid_hi - s_whi, 1);
        check("slow_aw_stall_cycles", aw_stall - s_stall, 3);
        check("slow_aw_hs", {8'(aw_hs_cnt - s_aw), 8'(w_hs_cnt - s_w), 8'(b_hs_cnt - s_b)}, 24'h010101);
        check("slow_aw_one_rsp", rsp_cnt - s_rsp, 1);
        check("bready_early", bready_early, 0);

        // Response backpressure with a queued request
        issue(0, 16'h0014, 32'h0, 4'h0);
        wait_rsp(d, e);
        check("bp_rdata", d, 32'h12345678);
        req_valid = 1; req_we = 0; req_addr = 16'h0010;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1 || rsp_rdata !== 32'h12345678 || req_ready !== 0 || arvalid !== 0)
                bad++;
        end
        check("bp_stall_stable", bad, 0);
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        check("bp_release", {rsp_valid, req_ready, arvalid}, 3'b010);
        @(posedge clk); #1;
        req_valid = 0;
        check("bp_new_accept", {arvalid, req_ready}, 2'b10);
        check("bp_new_araddr", araddr, 16'h0010);
        wait_rsp(d, e);
        check("bp_new_rdata", d, 32'hDEADABEF);
        consume();

        // Error responses
        rresp_cfg = 2'b10;
        issue(0, 16'h0010, 32'h0, 4'h0);
        wait_rsp(d, e);
        check("rresp_slverr", e, 1);
        consume();
        rresp_cfg = 2'b00;
        bresp_cfg = 2'b11;
        issue(1, 16'h0018, 32'h00000055, 4'hF);
        wait_rsp(d, e);
        check("bresp_decerr", e, 1);
        check("bresp_decerr_rdata", d, 0);
        consume();
        bresp_cfg = 2'b00;
        check("idle_after_err", req_ready, 1);

        // Reset while waiting for read data
        r_delay = 10;
        issue(0, 16'h0010, 32'h0, 4'h0);
        n = 0;
        while (rready !== 1'b1 && n < TMO) begin
            @(posedge clk); #1; n++;
        end
        check("mid_rst_reach_rd_data", 32'(n >= TMO), 0);
        check("mid_rst_ar_done", arvalid, 0);
        #2;
        rst_n = 0;
        #1;
        check("mid_rst_async_clear", {arvalid, rready, rsp_valid, req_ready, bready}, 0);
        s_rsphi = rsp_hi; s_rsp = rsp_cnt;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        r_delay = 0;
        @(posedge clk); #1;
        check("mid_rst_req_ready", req_ready, 1);
        repeat (15) @(posedge clk);
        #1;
        check("mid_rst_no_stale_rsp", rsp_hi - s_rsphi, 0);
        check("mid_rst_no_rsp_hs", rsp_cnt - s_rsp, 0);
        issue(0, 16'h0010, 32'h0, 4'h0);
        wait_rsp(d, e);
        check("post_rst_read", d, 32'hDEADABEF);
        consume();

        check("valid_withdrawn", withdrawn, 0);
        check("held_value_unstable", unstable, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
